// File: rtl/addsub_sweep_checker_pkg.sv
// addsub_sweep_checker_pkg: shared FSM states, widths and golden add/sub function
package addsub_sweep_checker_pkg;
  localparam int ADDSUB_WIDTH = 4;
  localparam int VEC_W = 2*ADDSUB_WIDTH+1;
  typedef enum logic [2:0] {ST_IDLE, ST_DRIVE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;
  function automatic logic [ADDSUB_WIDTH+1:0] addsub_golden(
    input logic [ADDSUB_WIDTH-1:0] a,
    input logic [ADDSUB_WIDTH-1:0] b,
    input logic m
  );
    logic [ADDSUB_WIDTH-1:0] bb;
    logic [ADDSUB_WIDTH:0] sum;
    bb = m ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{ADDSUB_WIDTH{1'b0}}, m};
    return {(a[ADDSUB_WIDTH-1] == bb[ADDSUB_WIDTH-1]) && (sum[ADDSUB_WIDTH-1] != a[ADDSUB_WIDTH-1]), sum};
  endfunction
endpackage

// File: rtl/addsub_sweep_checker_golden.sv
// addsub_golden_model: combinational reference adder/subtractor returning S, carry and signed overflow
module addsub_golden_model
  import addsub_sweep_checker_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v
);
  if (WIDTH == ADDSUB_WIDTH) begin : g_pkg
    assign {v, c, s} = addsub_golden(a, b, m);
  end else begin : g_gen
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0] sum;
    assign bb = m ? ~b : b;
    assign sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, m};
    assign {c, s} = sum;
    assign v = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end
endmodule

// File: rtl/addsub_sweep_checker.sv
// addsub_sweep_checker: exhaustive {m,a,b} sweep of an adder/subtractor with error count and first-fail capture
module addsub_sweep_checker
  import addsub_sweep_checker_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  output logic               m_o,
  input  logic [WIDTH-1:0]   s_i,
  input  logic               cout_i,
  input  logic               v_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH+1:0] err_count,
  output logic               first_fail_valid,
  output logic [2*WIDTH:0]   first_fail_vec,
  output logic [2*WIDTH:0]   vec_idx
);
  localparam int VW = 2*WIDTH+1;
  localparam int EW = 2*WIDTH+2;
  localparam int CW = $clog2(SETTLE_CYCLES+1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] vec_q, vec_d, op_q, op_d, ffvec_q, ffvec_d;
  logic [EW-1:0] err_q, err_d;
  logic ffv_q, ffv_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [WIDTH-1:0] g_s;
  logic g_c, g_v, mis;
  addsub_golden_model #(.WIDTH(WIDTH)) u_golden (
    .a(op_q[2*WIDTH-1:WIDTH]),
    .b(op_q[WIDTH-1:0]),
    .m(op_q[2*WIDTH]),
    .s(g_s),
    .c(g_c),
    .v(g_v)
  );
  assign mis = {v_i, cout_i, s_i} != {g_v, g_c, g_s};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    vec_d = vec_q;
    op_d = op_q;
    err_d = err_q;
    ffv_d = ffv_q;
    ffvec_d = ffvec_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) begin
        state_d = ST_DRIVE;
        vec_d = '0;
        err_d = '0;
        ffv_d = 1'b0;
        ffvec_d = '0;
      end
      ST_DRIVE: begin
        op_d = vec_q;
        cnt_d = CW'(SETTLE_CYCLES-1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == '0 ? ST_CHECK : ST_SETTLE;
      end
      ST_CHECK: begin
        if (mis) begin
          err_d = &err_q ? err_q : err_q + EW'(1);
          ffv_d = 1'b1;
          ffvec_d = ffv_q ? ffvec_q : vec_q;
        end
        vec_d = &vec_q ? vec_q : vec_q + VW'(1);
        state_d = &vec_q ? ST_DONE : ST_DRIVE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = state_d inside {ST_DRIVE, ST_SETTLE, ST_CHECK};
    done_d = state_d == ST_DONE;
    pass_d = done_d && err_d == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      vec_q <= '0;
      op_q <= '0;
      err_q <= '0;
      ffv_q <= 1'b0;
      ffvec_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vec_q <= vec_d;
      op_q <= op_d;
      err_q <= err_d;
      ffv_q <= ffv_d;
      ffvec_q <= ffvec_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
  assign {m_o, a_o, b_o} = op_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err_count = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec = ffvec_q;
  assign vec_idx = vec_q;
endmodule

// File: tb/tb_addsub_sweep_checker.sv
// tb_addsub_sweep_checker: directed sweeps against a fault-injectable 4-bit adder/subtractor
module tb_addsub_sweep_checker;
  import addsub_sweep_checker_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] a_o, b_o, s_i;
  logic m_o, cout_i, v_i, busy, done, pass, first_fail_valid;
  logic [9:0] err_count;
  logic [VEC_W-1:0] first_fail_vec, vec_idx;
  int fault = 0, tests = 0, fails = 0, cyc = 0, t0 = 0;
  int sa, sb, r;
  addsub_sweep_checker dut (
    .clk(clk), .rst(rst), .start(start),
    .a_o(a_o), .b_o(b_o), .m_o(m_o),
    .s_i(s_i), .cout_i(cout_i), .v_i(v_i),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_valid(first_fail_valid),
    .first_fail_vec(first_fail_vec), .vec_idx(vec_idx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    sa = a_o[3] ? int'(a_o) - 16 : int'(a_o);
    sb = b_o[3] ? int'(b_o) - 16 : int'(b_o);
    r = m_o ? sa - sb : sa + sb;
    s_i = r[3:0];
    if (fault == 1) s_i[0] = 1'b0;
    cout_i = (m_o ? a_o >= b_o : int'(a_o) + int'(b_o) > 15) ^ (fault == 2 && m_o);
    v_i = fault == 3 ? 1'b0 : (r > 7 || r < -8);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start_sweep();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t0 = cyc;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done, 1);
  endtask
  task automatic wait_vec(input int v);
    int n = 0;
    while (vec_idx != v[8:0] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("vec_reached", vec_idx, v);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_flags", {busy, done, pass, first_fail_valid, err_count}, 0);
    chk("rst_vecs", {first_fail_vec, vec_idx, m_o, a_o, b_o}, 0);
    rst = 1'b0;
    start_sweep();
    chk("busy_on_start", busy, 1);
    wait_done();
    chk("clean_cycles", cyc - t0, 2048);
    chk("clean_err", err_count, 0);
    chk("clean_pass", pass, 1);
    chk("clean_ffv", first_fail_valid, 0);
    chk("clean_ops_hold", {m_o, a_o, b_o}, 9'h1FF);
    chk("clean_busy_done", busy, 0);
    fault = 1;
    start_sweep();
    wait_done();
    chk("s0_err", err_count, 256);
    chk("s0_pass", pass, 0);
    chk("s0_ffv", first_fail_valid, 1);
    chk("s0_ffvec", first_fail_vec, 9'h001);
    fault = 2;
    start_sweep();
    wait_done();
    chk("cout_err", err_count, 256);
    chk("cout_ffvec", first_fail_vec, 9'h100);
    fault = 3;
    start_sweep();
    wait_done();
    chk("v_err", err_count, 128);
    chk("v_ffvec", first_fail_vec, 9'h017);
    fault = 0;
    start_sweep();
    chk("restart_done_drop", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_err_clear", err_count, 0);
    chk("restart_ffv_clear", first_fail_valid, 0);
    wait_vec(10);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();
    chk("ignore_cycles", cyc - t0, 2048);
    chk("ignore_err", err_count, 0);
    chk("ignore_pass", pass, 1);
    fault = 1;
    start_sweep();
    wait_vec(100);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("abort_flags", {busy, done, pass, first_fail_valid, err_count}, 0);
    chk("abort_vecs", {first_fail_vec, vec_idx, m_o, a_o, b_o}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle", {busy, done, vec_idx}, 0);
    fault = 0;
    start_sweep();
    wait_done();
    chk("post_abort_cycles", cyc - t0, 2048);
    chk("post_abort_err", err_count, 0);
    chk("post_abort_pass", pass, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/addsub_sweep_checker.md
Name: addsub_sweep_checker

Overview:
- Synthesizable response-side checker for the 4-bit adder/subtractor (inputs a, b, m; outputs S, Cout, V).
- On start, drives every {m,a,b} combination into the adder under test, waits a settle window, samples S/Cout/V and compares them against an internal golden model.
- Counts mismatches and latches the first failing vector. Used for on-board self-test and as the bench-side scoreboard.

Parameters:
- WIDTH, 4, operand width of the adder under test.
- SETTLE_CYCLES, 2, cycles between driving a vector and sampling the response (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sweep; ignored unless in IDLE or DONE.
- a_o  out  WIDTH  operand a to the adder.
- b_o  out  WIDTH  operand b to the adder.
- m_o  out  1  mode to the adder: 0 = add, 1 = subtract.
- s_i  in  WIDTH  adder sum/difference.
- cout_i  in  1  adder carry out.
- v_i  in  1  adder signed-overflow flag.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep end until the next start or reset.
- pass  out  1  valid when done; 1 iff err_count == 0.
- err_count  out  2*WIDTH+2  number of mismatching vectors; saturates at all-ones.
- first_fail_valid  out  1  set at the first mismatch of a sweep.
- first_fail_vec  out  2*WIDTH+1  {m,a,b} of the first mismatch.
- vec_idx  out  2*WIDTH+1  current vector {m,a,b}.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE. Reset takes effect mid-sweep: the sweep is aborted, no done pulse is produced, and counters are cleared.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE/DONE: start -> clear err_count, first_fail_valid, first_fail_vec, done and pass; set vec_idx=0; go to DRIVE.
- DRIVE (1 cycle): register {m_o,a_o,b_o}=vec_idx; load settle counter; go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles): hold outputs stable; go to CHECK when the counter expires.
- CHECK (1 cycle): compare s_i/cout_i/v_i with golden. Any bit differing is one error: err_count+1, saturating. On the first error, latch vec_idx into first_fail_vec and set first_fail_valid.
- CHECK exit: if vec_idx is all-ones, go to DONE; otherwise increment vec_idx (wrap-free) and go to DRIVE.
- DONE: done=1, pass=(err_count==0), busy=0. Operand outputs hold the last vector.
- Timing: each vector takes 2+SETTLE_CYCLES cycles. With defaults, a full sweep is 512 vectors x 4 = 2048 cycles from the first DRIVE; done rises the cycle after the last CHECK.
- busy=1 in DRIVE, SETTLE and CHECK. A start received while busy is ignored.
- Golden add (m=0): {C,S}=a+b over WIDTH+1 bits; V=(a[msb]==b[msb]) && (S[msb]!=a[msb]).
- Golden subtract (m=1): {C,S}=a+~b+1 over WIDTH+1 bits, so C is carry (not borrow): C=1 iff a>=b unsigned. V=(a[msb]!=b[msb]) && (S[msb]!=a[msb]).
- Inputs are sampled only in CHECK. Values seen on s_i/cout_i/v_i in other states are don't-care.

Decomposition:
- Shared package: FSM state encoding, WIDTH default, the vector-width constant 2*WIDTH+1, and the golden function addsub_golden(a,b,m) returning {V,C,S}.
- One sub-module, addsub_golden_model: a combinational golden model. The checker instantiates it.

Test Plan:
- Behavioural-correct adder, defaults, start pulse: done at cycle 2048 after the first DRIVE; err_count=0, pass=1, first_fail_valid=0.
- Adder with S[0] stuck-at-0: err_count=256, pass=0, first_fail_vec={0,0000,0001}.
- Adder with cout inverted only when m=1: err_count=256, first_fail_vec={1,0000,0000} (golden C=1, DUT 0).
- Adder with V stuck-at-0: err_count=128 (64 add and 64 subtract overflow cases), first_fail_vec={0,0001,0111}.
- Assert rst at vector 100 mid-sweep: next cycle all outputs are 0 and the FSM is in IDLE. A fresh start then completes a full clean 2048-cycle sweep.
- Pulse start while busy at vector 10: ignored, and the sweep completes at the original cycle count. Pulse start while in DONE: done drops next cycle and a new sweep begins.
